// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch front end.
// Exports XLEN, RESET_PC_DEF, INSTR_NOP and the fetch_entry_t bundle.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;
  localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Register-based prefetch FIFO holding {pc, instr} pairs.
// Ports: clk, rst (sync, active-low), push/push_data, pop, flush, head, empty, count.
module prefetch_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal alongside a pop.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: PC sequencer, credit-limited requests, prefetch FIFO, redirect/drop.
// Ports: clk, rst, req_*, rsp_*, redirect_*, out_* (valid/ready to decode).
module fetch_prefetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [XLEN-1:0] ALIGN = ~(XLEN'(3));

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     used;
  logic            fifo_empty;
  logic            req_fire;
  logic            keep;
  logic [XLEN-1:0] tgt;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Credits cover both buffered and in-flight words.
  assign used      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req_valid = rst && !redirect_valid
                  && (used < (CW+1)'(DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign req_addr  = fetch_pc;
  assign keep      = rsp_valid && (drop == '0);
  assign tgt       = redirect_pc & ALIGN;

  assign push_data.pc    = rsp_pc;
  assign push_data.instr = rsp_data;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data (push_data),
    .pop       (out_ready),
    .flush     (redirect_valid),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC & ALIGN;
      rsp_pc      <= RESET_PC & ALIGN;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= tgt;
      rsp_pc      <= tgt;
      // Everything still in flight belongs to the old stream.
      outstanding <= outstanding - CW'(rsp_valid);
      drop        <= outstanding - CW'(rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (rsp_valid) begin
        if (drop != '0) begin
          drop <= drop - CW'(1);
        end else begin
          rsp_pc <= rsp_pc + XLEN'(4);
        end
      end
      outstanding <= outstanding
                   + CW'(req_fire)
                   - CW'(rsp_valid);
    end
  end

  a_no_rsp_underflow: assert property (
    @(posedge clk) disable iff (!rst)
    rsp_valid |-> (outstanding != '0));

  a_drop_bound: assert property (
    @(posedge clk) disable iff (!rst)
    drop <= outstanding);

endmodule
